// File: rtl/cpu_bus_master.sv
// CPU-side bus master: serialises single-beat requests onto the shared C1/A1/D1 cache bus.
// Each request returns exactly one completion; a watchdog aborts transactions the cache never answers.
module cpu_bus_master #(
  parameter int CACHE_ADDR_SIZE   = 19,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int ADDR1_BUS_SIZE    = 15,
  parameter int DATA_BUS_SIZE     = 16,
  parameter int CTR1_BUS_SIZE     = 3,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_op,
  input  logic [CACHE_ADDR_SIZE-1:0] req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_rdata,
  output logic                       resp_err,
  inout  wire  [CTR1_BUS_SIZE-1:0]   C1,
  inout  wire  [ADDR1_BUS_SIZE-1:0]  A1,
  inout  wire  [DATA_BUS_SIZE-1:0]   D1
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP      = CTR1_BUS_SIZE'(0);
  localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE = CTR1_BUS_SIZE'(7);

  localparam logic [2:0] OP_READ8   = 3'd1;
  localparam logic [2:0] OP_READ16  = 3'd2;
  localparam logic [2:0] OP_READ32  = 3'd3;
  localparam logic [2:0] OP_WRITE8  = 3'd5;
  localparam logic [2:0] OP_WRITE16 = 3'd6;
  localparam logic [2:0] OP_WRITE32 = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR2, S_WAIT, S_RESP2} state_t;

  state_t                         state_q;
  logic [2:0]                     op_q;
  logic [CACHE_OFFSET_SIZE-1:0]   off_q;
  logic [15:0]                    wlo_q;
  logic [WD_W-1:0]                wd_q;
  logic                           req_ready_q;
  logic                           resp_valid_q;
  logic [31:0]                    resp_rdata_q;
  logic                           resp_err_q;
  logic [CTR1_BUS_SIZE-1:0]       c1_q;
  logic                           c1_oe_q;
  logic [ADDR1_BUS_SIZE-1:0]      a1_q;
  logic                           a1_oe_q;
  logic [DATA_BUS_SIZE-1:0]       d1_q;
  logic                           d1_oe_q;

  // The bus carries halves byte-swapped: D1[7:0] is the more significant byte.
  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [15:0] first_beat(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      OP_WRITE8:  return {8'h00, wd[7:0]};
      OP_WRITE16: return swap16(wd[15:0]);
      OP_WRITE32: return swap16(wd[31:16]);
      default:    return 16'h0000;
    endcase
  endfunction

  function automatic logic is_write(input logic [2:0] op);
    return (op == OP_WRITE8) || (op == OP_WRITE16) || (op == OP_WRITE32);
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      wlo_q        <= '0;
      wd_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      c1_q         <= C1_NOP;
      c1_oe_q      <= 1'b1;
      a1_q         <= '0;
      a1_oe_q      <= 1'b0;
      d1_q         <= '0;
      d1_oe_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            off_q       <= req_addr[CACHE_OFFSET_SIZE-1:0];
            wlo_q       <= req_wdata[15:0];
            wd_q        <= '0;
            req_ready_q <= 1'b0;
            c1_q        <= CTR1_BUS_SIZE'(req_op);
            a1_q        <= ADDR1_BUS_SIZE'(req_addr[CACHE_ADDR_SIZE-1:CACHE_OFFSET_SIZE]);
            a1_oe_q     <= 1'b1;
            d1_q        <= DATA_BUS_SIZE'(first_beat(req_op, req_wdata));
            d1_oe_q     <= is_write(req_op);
            state_q     <= S_CMD;
          end
        end
        S_CMD: begin
          a1_q <= ADDR1_BUS_SIZE'(off_q);
          if (op_q == OP_WRITE32) d1_q <= DATA_BUS_SIZE'(swap16(wlo_q));
          state_q <= S_ADDR2;
        end
        S_ADDR2: begin
          c1_oe_q <= 1'b0;
          a1_oe_q <= 1'b0;
          d1_oe_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the same edge as the watchdog limit still wins.
          if (C1 == C1_RESPONSE) begin
            if (op_q == OP_READ32) begin
              resp_rdata_q <= {swap16(D1[15:0]), 16'h0000};
              state_q      <= S_RESP2;
            end else begin
              if (op_q == OP_READ8)       resp_rdata_q <= {24'h0, D1[7:0]};
              else if (op_q == OP_READ16) resp_rdata_q <= {16'h0, swap16(D1[15:0])};
              else                        resp_rdata_q <= '0;
              resp_err_q   <= 1'b0;
              resp_valid_q <= 1'b1;
              req_ready_q  <= 1'b1;
              c1_q         <= C1_NOP;
              c1_oe_q      <= 1'b1;
              state_q      <= S_IDLE;
            end
          end else if (wd_q == WD_MAX) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            req_ready_q  <= 1'b1;
            c1_q         <= C1_NOP;
            c1_oe_q      <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_RESP2: begin
          resp_rdata_q[15:0] <= swap16(D1[15:0]);
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          req_ready_q  <= 1'b1;
          c1_q         <= C1_NOP;
          c1_oe_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign C1 = c1_oe_q ? c1_q : {CTR1_BUS_SIZE{1'bz}};
  assign A1 = a1_oe_q ? a1_q : {ADDR1_BUS_SIZE{1'bz}};
  assign D1 = d1_oe_q ? d1_q : {DATA_BUS_SIZE{1'bz}};

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Upstream CPU-side bus master for the cache.
- Accepts single-beat requests on a simple valid/ready front end and serialises each onto the shared C1/A1/D1 bus in the cache protocol.
- Command and two-part address, write data in 16-bit halves, bus release, wait for C1_RESPONSE, collection of read data.
- Returns one completion per request; a watchdog aborts transactions the cache never answers.

Parameters:
- CACHE_ADDR_SIZE, 19, full byte address width (tag+set+offset).
- CACHE_OFFSET_SIZE, 4, offset bits carried in the second A1 beat.
- ADDR1_BUS_SIZE, 15, A1 width (>= CACHE_ADDR_SIZE-CACHE_OFFSET_SIZE).
- DATA_BUS_SIZE, 16, D1 width; fixed at 16.
- CTR1_BUS_SIZE, 3, C1 width.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort; must be >=1.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_op  in  3  C1 command code: C1_READ8/16/32, C1_INVALIDATE_LINE, C1_WRITE8/16/32.
- req_addr  in  CACHE_ADDR_SIZE  byte address.
- req_wdata  in  32  write data, right-aligned (8-bit in [7:0], 16-bit in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data, zero-extended, right-aligned; 0 for writes, invalidate and abort.
- resp_err  out  1  qualifies resp_valid; 1 = watchdog abort.
- C1  inout  CTR1_BUS_SIZE  control bus.
- A1  inout  ADDR1_BUS_SIZE  address bus.
- D1  inout  DATA_BUS_SIZE  data bus.

Behaviour:
- Encodings: C1_NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7, C1_RESPONSE=7 (direction disambiguates).
- Reset (RESET_N low, async):
  - State IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, watchdog=0.
  - C1 driven C1_NOP; A1 and D1 high-Z.
  - Reset mid-transaction: drop it silently, no resp_valid, bus returns to the reset state immediately.
- Drive ownership:
  - C1 is driven only in IDLE, CMD and ADDR2, otherwise Z.
  - A1 is driven only in CMD and ADDR2.
  - D1 is driven only in CMD and ADDR2 for write ops, otherwise Z.
- States:
  - IDLE: C1=C1_NOP, req_ready=1. An accepted request latches op/addr/wdata → CMD.
  - CMD (1 cycle): C1=op; A1=addr[CACHE_ADDR_SIZE-1:CACHE_OFFSET_SIZE].
    - WRITE8: D1[7:0]=wdata[7:0], D1[15:8]=0.
    - WRITE16: D1[7:0]=wdata[15:8], D1[15:8]=wdata[7:0].
    - WRITE32: D1[7:0]=wdata[31:24], D1[15:8]=wdata[23:16].
    - → ADDR2.
  - ADDR2 (1 cycle): C1 holds op; A1=zero-extended addr[CACHE_OFFSET_SIZE-1:0].
    - WRITE32: D1[7:0]=wdata[15:8], D1[15:8]=wdata[7:0]. Other writes hold the CMD value.
    - → WAIT.
  - WAIT: all buses Z; watchdog increments each cycle.
    - At an edge with C1==C1_RESPONSE:
      - READ8: rdata={24'b0, D1[7:0]}.
      - READ16: rdata={16'b0, D1[7:0], D1[15:8]}.
      - READ32: capture {D1[7:0], D1[15:8]} into rdata[31:16] → RESP2.
      - All other ops → IDLE with resp_valid=1.
    - Watchdog reaching TIMEOUT_CYCLES without response → IDLE, resp_valid=1, resp_err=1, rdata=0.
  - RESP2 (1 cycle, buses Z): sample {D1[7:0], D1[15:8]} into rdata[15:0] at the next edge → IDLE, resp_valid=1.
- req_ready is 0 in CMD, ADDR2, WAIT and RESP2.
- resp_valid is registered and coincides with the first IDLE cycle, so back-to-back requests are legal.
- A request accepted in that cycle enters CMD at the next edge, giving one C1_NOP-driven cycle between transactions.
- The watchdog clears on entry to CMD.
- Latency from the accept edge E to resp_valid: E+3+w cycles (w = WAIT cycles before the response edge); +1 for READ32.
- C1==C1_RESPONSE seen in CMD/ADDR2 is ignored: the master is driving C1.
- An unknown req_op (0) is accepted and treated as INVALIDATE_LINE-style: no data phase, awaits response.

Test Plan:
- Reset then idle: RESET_N=0 → C1=0, A1/D1=Z, req_ready=1; release, 5 cycles → no resp_valid.
- WRITE32 addr 0x12345 data 0xDEADBEEF:
  - CMD: C1=7, A1=0x1234, D1=0xADDE. ADDR2: A1=0x5, D1=0xEFBE.
  - Then Z; model responds C1=7 after 4 cycles → resp_valid=1, resp_err=0, rdata=0.
- READ16 addr 0x00010: A1 beats 0x0001 then 0x0 → model returns D1=0x3412 with C1_RESPONSE → rdata=0x00001234.
- READ32 addr 0x7FFF0: responses D1=0x2211 then 0x4433 on consecutive edges → rdata=0x11223344, resp_valid exactly once.
- READ8 with no responder, TIMEOUT_CYCLES=8 → resp_valid with resp_err=1, rdata=0 at E+3+8; C1 returns to C1_NOP.
- Async reset asserted during WAIT of WRITE8 → buses Z/NOP immediately, no resp_valid; a following READ8 completes normally.
